// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller for the MIPS datapath.
//
// Accepts one request at a time over a valid/ready handshake, waits LATENCY
// cycles, then performs a byte/halfword/word access on a word-organised array
// and returns a one-cycle response pulse.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_valid_i        request present
//   req_ready_o        controller idle and able to accept
//   req_we_i           1 = store, 0 = load
//   req_size_i         00 byte, 01 half, 10 word, 11 reserved (error)
//   req_unsigned_i     loads: 1 = zero-extend, 0 = sign-extend
//   req_addr_i         byte address
//   req_wdata_i        right-aligned store data
//   rsp_valid_o        one-cycle response pulse
//   rsp_rdata_o        load result (0 for stores and errors)
//   rsp_err_o          access rejected (size 11, out of range, misaligned)
//
// Build option: define DMEM_MISALIGN_ERR_EN to reject misaligned half/word
// accesses; otherwise misaligned addresses are aligned down.
module dmem_ctrl #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [31:0]       rsp_rdata_q;

  logic [31:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] addr_eff;
  logic              misalign;
  logic              misalign_err;
  logic              oor;
  logic              err;
  logic [IdxW-1:0]   idx;
  logic [1:0]        lane;
  logic [3:0]        be;
  logic [31:0]       wlanes;
  logic [31:0]       shifted;
  logic [31:0]       ld;
  logic              access;

  // Decode of the latched request; only consumed on the access edge.
  always_comb begin
    addr_eff = addr_q;
    misalign = ((size_q == 2'b01) && addr_q[0]) ||
               ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
`ifdef DMEM_MISALIGN_ERR_EN
    misalign_err = misalign;
`else
    misalign_err = 1'b0;
    if (size_q == 2'b01) addr_eff[0] = 1'b0;
    if (size_q == 2'b10) addr_eff[1:0] = 2'b00;
`endif
    // Any bit above the word-index field means the address is past the array.
    oor  = |(addr_eff >> (IdxW + 2));
    idx  = addr_eff[IdxW+1:2];
    lane = addr_eff[1:0];
    err  = (size_q == 2'b11) || oor || misalign_err;

    unique case (size_q)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = 4'b0011 << lane;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase

    // Replicate store data so every candidate lane sees the right bytes.
    unique case (size_q)
      2'b00:   wlanes = {4{wdata_q[7:0]}};
      2'b01:   wlanes = {2{wdata_q[15:0]}};
      default: wlanes = wdata_q;
    endcase

    shifted = mem_q[idx] >> {lane, 3'b000};
    unique case (size_q)
      2'b00:   ld = uns_q ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   ld = uns_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      2'b10:   ld = shifted;
      default: ld = 32'b0;
    endcase

    access = (state_q == StWait) && (cnt_q == 4'd0);
  end

  // StWait spans the LATENCY wait cycles plus the cycle ending in the access
  // edge, so the response registers at accept + LATENCY + 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            we_q    <= req_we_i;
            size_q  <= req_size_i;
            uns_q   <= req_unsigned_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            cnt_q   <= 4'(LATENCY);
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err;
            rsp_rdata_q <= (err || we_q) ? 32'b0 : ld;
            state_q     <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= 32'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Array is never cleared; reset only blocks an in-flight commit.
  always_ff @(posedge clk) begin
    if (!rst && access && we_q && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  assign req_ready_o = (state_q == StIdle) && !rst;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: instance 0 runs LATENCY=1, instance 1 runs
// LATENCY=3 for the reset-abort scenario.
module tb_dmem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [2];
  logic        valid  [2];
  logic        we     [2];
  logic [1:0]  size   [2];
  logic        uns    [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic        ready  [2];
  logic        rvalid [2];
  logic [31:0] rdata  [2];
  logic        err    [2];

  int total = 0;
  int bad   = 0;

  dmem_ctrl #(.DEPTH(256), .LATENCY(1), .ADDR_W(32)) u_dut (
    .clk(clk), .rst(rst[0]),
    .req_valid_i(valid[0]), .req_ready_o(ready[0]), .req_we_i(we[0]),
    .req_size_i(size[0]), .req_unsigned_i(uns[0]), .req_addr_i(addr[0]),
    .req_wdata_i(wdata[0]), .rsp_valid_o(rvalid[0]), .rsp_rdata_o(rdata[0]),
    .rsp_err_o(err[0])
  );

  dmem_ctrl #(.DEPTH(256), .LATENCY(3), .ADDR_W(32)) u_dut3 (
    .clk(clk), .rst(rst[1]),
    .req_valid_i(valid[1]), .req_ready_o(ready[1]), .req_we_i(we[1]),
    .req_size_i(size[1]), .req_unsigned_i(uns[1]), .req_addr_i(addr[1]),
    .req_wdata_i(wdata[1]), .rsp_valid_o(rvalid[1]), .rsp_rdata_o(rdata[1]),
    .rsp_err_o(err[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One request on instance k; checks ready, response latency, rdata and err.
  task automatic xact(input int k, input string tag, input logic w, input logic [1:0] sz,
                      input logic u, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    @(negedge clk);
    check({tag, "/ready"}, 32'(ready[k]), 32'd1);
    valid[k] = 1'b1; we[k] = w; size[k] = sz; uns[k] = u; addr[k] = a; wdata[k] = d;
    @(posedge clk); #1;
    // Scramble inputs after the accept edge; they must be ignored.
    valid[k] = 1'b0; we[k] = ~w; size[k] = ~sz; uns[k] = ~u; addr[k] = ~a; wdata[k] = ~d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (rvalid[k] !== 1'b1 && n < 20);
    check({tag, "/lat"}, 32'(n), (k == 0) ? 32'd2 : 32'd4);
    check({tag, "/rdata"}, rdata[k], exp_rdata);
    check({tag, "/err"}, 32'(err[k]), 32'(exp_err));
    @(posedge clk); #1;
    check({tag, "/pulse"}, 32'(rvalid[k]), 32'd0);
  endtask

  initial begin
    int seen;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; valid[k] = 1'b0; we[k] = 1'b0; size[k] = 2'b00; uns[k] = 1'b0;
      addr[k] = 32'h0; wdata[k] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready[0]), 32'd0);
    check("rst_rvalid", 32'(rvalid[0]), 32'd0);
    check("rst_err", 32'(err[0]), 32'd0);
    check("rst_rdata", rdata[0], 32'd0);
    rst[0] = 1'b0; rst[1] = 1'b0;
    #1;
    check("post_rst_ready", 32'(ready[0]), 32'd1);

    // Word store/load, byte merge, signed/unsigned byte loads.
    xact(0, "st_w24", 1'b1, 2'b10, 1'b0, 32'h24, 32'h12345678, 32'h0, 1'b0);
    xact(0, "ld_w24", 1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 32'h12345678, 1'b0);
    xact(0, "st_b25", 1'b1, 2'b00, 1'b0, 32'h25, 32'hFFFFFFAB, 32'h0, 1'b0);
    xact(0, "ld_w24b", 1'b0, 2'b10, 1'b1, 32'h24, 32'h0, 32'h1234AB78, 1'b0);
    xact(0, "ld_bs25", 1'b0, 2'b00, 1'b0, 32'h25, 32'h0, 32'hFFFFFFAB, 1'b0);
    xact(0, "ld_bu25", 1'b0, 2'b00, 1'b1, 32'h25, 32'h0, 32'h000000AB, 1'b0);

    // Halfword lanes and extension.
    xact(0, "st_w24h", 1'b1, 2'b10, 1'b0, 32'h24, 32'h80017FFF, 32'h0, 1'b0);
    xact(0, "ld_hs26", 1'b0, 2'b01, 1'b0, 32'h26, 32'h0, 32'hFFFF8001, 1'b0);
    xact(0, "ld_hs24", 1'b0, 2'b01, 1'b0, 32'h24, 32'h0, 32'h00007FFF, 1'b0);
    xact(0, "ld_hu26", 1'b0, 2'b01, 1'b1, 32'h26, 32'h0, 32'h00008001, 1'b0);

    // Range and reserved-size errors.
    xact(0, "st_w00", 1'b1, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0);
    xact(0, "st_oor", 1'b1, 2'b10, 1'b0, 32'h400, 32'hDEADBEEF, 32'h0, 1'b1);
    xact(0, "ld_w00", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0);
    xact(0, "ld_sz3", 1'b0, 2'b11, 1'b0, 32'h24, 32'h0, 32'h0, 1'b1);
    xact(0, "st_sz3", 1'b1, 2'b11, 1'b0, 32'h24, 32'h0, 32'h0, 1'b1);
    xact(0, "ld_w24c", 1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 32'h80017FFF, 1'b0);

    // Misaligned word load.
`ifdef DMEM_MISALIGN_ERR_EN
    xact(0, "ld_mis26", 1'b0, 2'b10, 1'b0, 32'h26, 32'h0, 32'h0, 1'b1);
`else
    xact(0, "ld_mis26", 1'b0, 2'b10, 1'b0, 32'h26, 32'h0, 32'h80017FFF, 1'b0);
`endif

    // LATENCY=3: reset during WAIT aborts a store.
    xact(1, "l3_st10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h11111111, 32'h0, 1'b0);
    @(negedge clk);
    valid[1] = 1'b1; we[1] = 1'b1; size[1] = 2'b10; uns[1] = 1'b0;
    addr[1] = 32'h10; wdata[1] = 32'h22222222;
    @(posedge clk); #1;
    valid[1] = 1'b0;
    @(posedge clk); #1;
    rst[1] = 1'b1;
    #1;
    check("l3_rst_ready", 32'(ready[1]), 32'd0);
    @(posedge clk); #1;
    rst[1] = 1'b0;
    #1;
    check("l3_post_rst_ready", 32'(ready[1]), 32'd1);
    seen = 0;
    repeat (6) begin
      if (rvalid[1] !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    check("l3_no_rsp", 32'(seen), 32'd0);
    xact(1, "l3_ld10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h11111111, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
